gpu_compositor_m: RTL and testbench
===================================

// Module: gpu_compositor_m
// PURPOSE
//  Parametrised pixel compositor: successor to the fixed 2-layer GPU colour mux.
//  - Merges LAYERS layer pixels, selected by per-layer valid and a programmable priority.
//  - Adds backdrop and border colours and a per-layer enable mask.
//  - Config is double-buffered and committed at frame start; a 2-stage pipeline keeps syncs aligned.
//  - Sits between video timing/layer renderers and the DAC pins.
// PARAMETERS
//  LAYERS      2    number of layer inputs, 1..8; layer 0 = highest priority by default
//  COLOR_BITS  2    bits per colour channel, 1..2 (3*COLOR_BITS <= 8)
//  X_OFFSET    32   hcounter value of first active pixel column
//  H_ACTIVE    256  drawn width in pixels
//  V_ACTIVE    240  drawn height in pixels (yp = vcounter[9:1])
// PORTS
//  clk          in   1                    pixel clock
//  rst          in   1                    synchronous reset, active-low
//  hcounter     in   10                   horizontal counter from video timing
//  vcounter     in   10                   vertical counter from video timing
//  visible      in   1                    counters in display region
//  hsync_in     in   1                    hsync from timing, active-low
//  vsync_in     in   1                    vsync from timing, active-low
//  layer_rgb    in   LAYERS*3*COLOR_BITS  layer i = bits [i*3*CB +: 3*CB], ordered {r,g,b}
//  layer_valid  in   LAYERS               layer i pixel is opaque
//  cfg_we       in   1                    config write strobe
//  cfg_addr     in   2                    config register select
//  cfg_data     in   8                    config write data
//  r, g, b      out  COLOR_BITS each      registered colour out
//  hsync, vsync out  1                    syncs delayed to match colour
// BEHAVIOUR
//  - Reset (rst=0 at posedge): r,g,b=0; hsync=vsync=1; both pipe stages flushed (syncs 1, colour 0).
//    Shadow and active config reset to enable=all 1s, backdrop=0, border=0, reverse=0.
//  - Config regs (shadow; cfg_we writes cfg_data on posedge):
//      0: layer_enable[LAYERS-1:0]   1: backdrop[3*CB-1:0]   2: border[3*CB-1:0]   3: bit0 reverse
//    Unused upper data bits are ignored.
//  - Commit: the cycle with hcounter==0 && vcounter==0 copies shadow -> active.
//    Write and commit in the same cycle: active gets the pre-write shadow; the write lands next frame.
//  - Stage 0 (combinational): xp = hcounter[8:0]-X_OFFSET (9-bit wrap); yp = vcounter[9:1];
//    drawing = visible && xp<H_ACTIVE && yp<V_ACTIVE.
//  - Stage 1 (reg): latch layer_rgb, layer_valid&active_enable, drawing, visible, hsync_in, vsync_in.
//  - Stage 2 (reg) colour select:
//      !visible               -> 0
//      visible && !drawing    -> border
//      drawing                -> first valid+enabled layer in priority order (0..L-1, or L-1..0 if
//                                reverse); if none -> backdrop
//  - Latency: counters/layers/syncs at edge N appear on outputs after edge N+2. Syncs are pure 2-deep delays.
//  - Layers sampled with the same counters; renderers own their own latency.
//  - Config changes never affect pixels mid-frame; only the commit cycle updates active regs.
//  - Reset mid-line: outputs return to reset values on that edge. Config returns to defaults.
//    First valid pixel appears 2 cycles after rst rises.
// TESTING
//  - Reset: hold rst=0 4 cycles with random inputs -> r,g,b=0, hsync=vsync=1 every cycle.
//  - Latency: hcounter=40 (xp=8), vcounter=20, visible=1, layer1 valid rgb=6'b110011, layer0 invalid ->
//    {r,g,b}=6'b110011 exactly 2 cycles later; hsync_in pulse emerges 2 cycles delayed.
//  - Priority: both layers valid (L0=6'h3F, L1=6'h15) -> 6'h3F; write reg3=1 and reach commit ->
//    6'h15; enable=2'b10 -> 6'h15 regardless of reverse.
//  - Backdrop/border: backdrop=6'h2A, no layer valid, xp=100 -> 6'h2A; border=6'h05, hcounter=10
//    (xp wraps to 490), visible=1 -> 6'h05; visible=0 -> 0.
//  - Double buffer: write backdrop=6'h11 mid-frame -> old backdrop until hcounter=vcounter=0
//    commit, then 6'h11. Write on commit cycle -> takes effect one frame later.
//  - Edges: xp=255 drawn, xp=256 border; yp=239 (vcounter=479) drawn, vcounter=480 border;
//    LAYERS=4 sweep of valid masks -> lowest-index valid enabled layer wins.

Source files
------------

// File: rtl/gpu_compositor_m.sv
// gpu_compositor_m: parametrised layer compositor with double-buffered config.
// Stage 0 is the combinational position decode. Stage 1 registers the inputs.
// Stage 2 registers the selected colour and the syncs.
module gpu_compositor_m #(
    parameter int LAYERS     = 2,
    parameter int COLOR_BITS = 2,
    parameter int X_OFFSET   = 32,
    parameter int H_ACTIVE   = 256,
    parameter int V_ACTIVE   = 240
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [9:0]                     hcounter,
    input  logic [9:0]                     vcounter,
    input  logic                           visible,
    input  logic                           hsync_in,
    input  logic                           vsync_in,
    input  logic [LAYERS*3*COLOR_BITS-1:0] layer_rgb,
    input  logic [LAYERS-1:0]              layer_valid,
    input  logic                           cfg_we,
    input  logic [1:0]                     cfg_addr,
    input  logic [7:0]                     cfg_data,
    output logic [COLOR_BITS-1:0]          r,
    output logic [COLOR_BITS-1:0]          g,
    output logic [COLOR_BITS-1:0]          b,
    output logic                           hsync,
    output logic                           vsync
);

    localparam int PW = 3*COLOR_BITS;
    localparam logic [8:0] X_OFF9 = 9'(X_OFFSET);
    localparam logic [9:0] H_ACT10 = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT10 = 10'(V_ACTIVE);

    typedef struct packed {
        logic [LAYERS-1:0] en;
        logic [PW-1:0]     backdrop;
        logic [PW-1:0]     border;
        logic              rev;
    } cfg_t;

    typedef struct packed {
        logic [LAYERS-1:0][PW-1:0] rgb;
        logic [LAYERS-1:0]         valid;
        logic                      draw;
        logic                      vis;
        logic                      hs;
        logic                      vs;
    } s1_t;

    typedef struct packed {
        logic [PW-1:0] rgb;
        logic          hs;
        logic          vs;
    } s2_t;

    localparam cfg_t CFG_RST = '{en: {LAYERS{1'b1}}, backdrop: '0, border: '0, rev: 1'b0};
    localparam s1_t  S1_RST  = '{rgb: '0, valid: '0, draw: 1'b0, vis: 1'b0, hs: 1'b1, vs: 1'b1};
    localparam s2_t  S2_RST  = '{rgb: '0, hs: 1'b1, vs: 1'b1};

    cfg_t shadow_q, shadow_d;
    cfg_t active_q, active_d;
    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;

    logic          commit;
    logic [8:0]    xp;
    logic [8:0]    yp;
    logic          drawing;
    logic [PW-1:0] fwd_rgb, rev_rgb, sel_rgb;
    logic          fwd_hit, rev_hit;

    // Upper config data bits have no register behind them.
    logic cfg_unused;
    assign cfg_unused = ^cfg_data;

    // Start-of-frame: the only moment the visible config may change.
    assign commit = (hcounter == 10'd0) && (vcounter == 10'd0);

    // Shadow writes from the CPU side; active copies the pre-write shadow on commit.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (cfg_we) begin
            case (cfg_addr)
                2'd0: shadow_d.en       = cfg_data[LAYERS-1:0];
                2'd1: shadow_d.backdrop = cfg_data[PW-1:0];
                2'd2: shadow_d.border   = cfg_data[PW-1:0];
                default: shadow_d.rev   = cfg_data[0];
            endcase
        end
        if (commit) active_d = shadow_q;
    end

    // Stage 0: decode screen position; xp wraps so columns left of X_OFFSET fall outside.
    always_comb begin
        xp      = hcounter[8:0] - X_OFF9;
        yp      = vcounter[9:1];
        drawing = visible && ({1'b0, xp} < H_ACT10) && ({1'b0, yp} < V_ACT10);
    end

    // Stage 1 capture; the layer enable mask is folded into valid here.
    always_comb begin
        s1_d.rgb   = layer_rgb;
        s1_d.valid = layer_valid & active_q.en;
        s1_d.draw  = drawing;
        s1_d.vis   = visible;
        s1_d.hs    = hsync_in;
        s1_d.vs    = vsync_in;
    end

    // Priority pick both directions: lowest-index hit forward, highest-index hit reversed.
    always_comb begin
        fwd_rgb = '0;
        fwd_hit = 1'b0;
        rev_rgb = '0;
        rev_hit = 1'b0;
        for (int k = LAYERS-1; k >= 0; k--) begin
            if (s1_q.valid[k]) begin
                fwd_rgb = s1_q.rgb[k];
                fwd_hit = 1'b1;
            end
        end
        for (int k = 0; k < LAYERS; k++) begin
            if (s1_q.valid[k]) begin
                rev_rgb = s1_q.rgb[k];
                rev_hit = 1'b1;
            end
        end
        if (active_q.rev) sel_rgb = rev_hit ? rev_rgb : active_q.backdrop;
        else              sel_rgb = fwd_hit ? fwd_rgb : active_q.backdrop;
    end

    // Stage 2: blank / border / layer-or-backdrop colour; syncs ride along.
    always_comb begin
        s2_d.hs = s1_q.hs;
        s2_d.vs = s1_q.vs;
        if (!s1_q.vis)       s2_d.rgb = '0;
        else if (!s1_q.draw) s2_d.rgb = active_q.border;
        else                 s2_d.rgb = sel_rgb;
    end

    // All state registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_q <= CFG_RST;
            active_q <= CFG_RST;
            s1_q     <= S1_RST;
            s2_q     <= S2_RST;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
        end
    end

    assign r     = s2_q.rgb[PW-1 -: COLOR_BITS];
    assign g     = s2_q.rgb[2*COLOR_BITS-1 -: COLOR_BITS];
    assign b     = s2_q.rgb[COLOR_BITS-1:0];
    assign hsync = s2_q.hs;
    assign vsync = s2_q.vs;

endmodule

// File: tb/tb_gpu_compositor_m.sv
// Directed bench for gpu_compositor_m: a 2-layer and a 4-layer instance.
module tb_gpu_compositor_m;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] hcounter, vcounter;
    logic       visible, hsync_in, vsync_in;
    logic [11:0] layer_rgb;
    logic [1:0]  layer_valid;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic [1:0]  r, g, b;
    logic        hsync, vsync;

    logic [23:0] rgb4;
    logic [3:0]  valid4;
    logic        cfg_we4 = 1'b0;
    logic [1:0]  r4, g4, b4;
    logic        hs4, vs4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gpu_compositor_m u_dut (
        .clk(clk), .rst(rst), .hcounter(hcounter), .vcounter(vcounter), .visible(visible),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .layer_rgb(layer_rgb), .layer_valid(layer_valid),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync)
    );

    gpu_compositor_m #(.LAYERS(4)) u_dut4 (
        .clk(clk), .rst(rst), .hcounter(hcounter), .vcounter(vcounter), .visible(visible),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .layer_rgb(rgb4), .layer_valid(valid4),
        .cfg_we(cfg_we4), .cfg_addr(2'd0), .cfg_data(8'd0),
        .r(r4), .g(g4), .b(b4), .hsync(hs4), .vsync(vs4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        step();
        step();
    endtask

    task automatic px(input logic [9:0] h, input logic [9:0] v, input logic vis);
        hcounter = h;
        vcounter = v;
        visible  = vis;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_we   = 1'b0;
    endtask

    // One cycle at hcounter=vcounter=0, then back to the previous position.
    task automatic commit();
        logic [9:0] h, v;
        logic       vis;
        h = hcounter; v = vcounter; vis = visible;
        px(10'd0, 10'd0, 1'b0);
        step();
        px(h, v, vis);
    endtask

    function automatic logic [5:0] rgb6();
        return {r, g, b};
    endfunction

    // Expected winner for each 4-layer valid mask (L0=01, L1=02, L2=04, L3=08).
    logic [5:0] exp4 [16] = '{6'h00, 6'h01, 6'h02, 6'h01, 6'h04, 6'h01, 6'h02, 6'h01,
                              6'h08, 6'h01, 6'h02, 6'h01, 6'h04, 6'h01, 6'h02, 6'h01};

    initial begin
        rst = 1'b0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'd0;
        rgb4 = {6'h08, 6'h04, 6'h02, 6'h01};
        valid4 = 4'd0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            hcounter    = 10'($urandom);
            vcounter    = 10'($urandom);
            visible     = 1'($urandom);
            hsync_in    = 1'($urandom);
            vsync_in    = 1'($urandom);
            layer_rgb   = 12'($urandom);
            layer_valid = 2'($urandom);
            cfg_we      = 1'($urandom);
            cfg_addr    = 2'($urandom);
            cfg_data    = 8'($urandom);
            step();
            chk("reset_rgb", 32'(rgb6()), 32'h0);
            chk("reset_sync", {30'd0, hsync, vsync}, 32'h3);
        end
        cfg_we = 1'b0;
        rst = 1'b1;
        px(10'd40, 10'd20, 1'b1);
        hsync_in = 1'b1; vsync_in = 1'b1;
        layer_rgb = 12'd0; layer_valid = 2'b00;
        settle();
        chk("idle_backdrop", 32'(rgb6()), 32'h0);

        // Latency: layer1 only, hsync pulse alongside
        layer_rgb = {6'b110011, 6'b000000};
        layer_valid = 2'b10;
        hsync_in = 1'b0;
        step();
        chk("lat_n1_rgb", 32'(rgb6()), 32'h0);
        chk("lat_n1_hs", 32'(hsync), 32'h1);
        hsync_in = 1'b1;
        step();
        chk("lat_n2_rgb", 32'(rgb6()), 32'h33);
        chk("lat_n2_hs", 32'(hsync), 32'h0);
        step();
        chk("lat_n3_hs", 32'(hsync), 32'h1);

        // Priority and reverse
        layer_rgb = {6'h15, 6'h3F};
        layer_valid = 2'b11;
        settle();
        chk("prio_fwd", 32'(rgb6()), 32'h3F);
        cfg_wr(2'd3, 8'h01);
        settle();
        chk("prio_rev_uncommitted", 32'(rgb6()), 32'h3F);
        commit(); settle();
        chk("prio_rev", 32'(rgb6()), 32'h15);
        cfg_wr(2'd0, 8'h02); commit(); settle();
        chk("en10_rev1", 32'(rgb6()), 32'h15);
        cfg_wr(2'd3, 8'h00); commit(); settle();
        chk("en10_rev0", 32'(rgb6()), 32'h15);
        cfg_wr(2'd0, 8'hFF); commit(); settle();
        chk("en_all", 32'(rgb6()), 32'h3F);

        // Backdrop / border / blank
        cfg_wr(2'd1, 8'h2A); commit();
        layer_valid = 2'b00;
        px(10'd132, 10'd20, 1'b1); settle();
        chk("backdrop", 32'(rgb6()), 32'h2A);
        cfg_wr(2'd2, 8'h05); commit();
        px(10'd10, 10'd20, 1'b1); settle();
        chk("border_xwrap", 32'(rgb6()), 32'h05);
        px(10'd10, 10'd20, 1'b0); settle();
        chk("blank", 32'(rgb6()), 32'h0);

        // Double buffering
        px(10'd132, 10'd20, 1'b1);
        cfg_wr(2'd1, 8'h11); settle();
        chk("dbuf_old", 32'(rgb6()), 32'h2A);
        commit(); settle();
        chk("dbuf_new", 32'(rgb6()), 32'h11);
        px(10'd0, 10'd0, 1'b0);
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 8'h22;
        step();
        cfg_we = 1'b0;
        px(10'd132, 10'd20, 1'b1); settle();
        chk("dbuf_wr_on_commit", 32'(rgb6()), 32'h11);
        commit(); settle();
        chk("dbuf_next_frame", 32'(rgb6()), 32'h22);

        // Drawing-area edges
        layer_rgb = {6'h00, 6'h3F};
        layer_valid = 2'b01;
        px(10'd287, 10'd20, 1'b1); settle();
        chk("edge_xp255", 32'(rgb6()), 32'h3F);
        px(10'd288, 10'd20, 1'b1); settle();
        chk("edge_xp256", 32'(rgb6()), 32'h05);
        px(10'd40, 10'd479, 1'b1); settle();
        chk("edge_v479", 32'(rgb6()), 32'h3F);
        px(10'd40, 10'd480, 1'b1); settle();
        chk("edge_v480", 32'(rgb6()), 32'h05);

        // Mid-line reset: outputs cleared, config back to defaults
        px(10'd132, 10'd20, 1'b1);
        layer_valid = 2'b00;
        settle();
        chk("pre_reset", 32'(rgb6()), 32'h22);
        hsync_in = 1'b0; vsync_in = 1'b0;
        rst = 1'b0;
        step();
        chk("midreset_rgb", 32'(rgb6()), 32'h0);
        chk("midreset_sync", {30'd0, hsync, vsync}, 32'h3);
        rst = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1;
        settle();
        chk("post_reset_backdrop", 32'(rgb6()), 32'h0);
        layer_valid = 2'b10;
        layer_rgb = {6'h15, 6'h3F};
        settle();
        chk("post_reset_pixel", 32'(rgb6()), 32'h15);

        // 4-layer valid-mask sweep
        px(10'd40, 10'd20, 1'b1);
        for (int m = 0; m < 16; m++) begin
            valid4 = 4'(m);
            settle();
            chk($sformatf("l4_mask%0d", m), 32'({r4, g4, b4}), 32'(exp4[m]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
